// File: rtl/cell_pkg.sv
// cell_pkg: shared defaults and width helper for the FIFO cell.
package cell_pkg;
    localparam int DEF_WIDTH = 8;
    localparam int DEF_DEPTH = 4;
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction
endpackage

// File: rtl/fifo_mem.sv
// fifo_mem: WIDTH x DEPTH storage, one write port and one registered read port.
module fifo_mem
    import cell_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH,
    parameter int AW    = clog2(DEPTH)
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_we,
    input  logic [AW-1:0]    i_waddr,
    input  logic [WIDTH-1:0] i_wdata,
    input  logic             i_re,
    input  logic [AW-1:0]    i_raddr,
    output logic [WIDTH-1:0] o_rdata
);
    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [WIDTH-1:0] r_rdata;

    always_ff @(posedge i_clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    // Read sees the pre-write word, so a full-FIFO read+write returns the oldest entry.
    always_ff @(posedge i_clk) begin
        if (i_rst) r_rdata <= '0;
        else if (i_re) r_rdata <= r_mem[i_raddr];
    end

    assign o_rdata = r_rdata;
endmodule

// File: rtl/sync_fifo_cell.sv
// sync_fifo_cell: synchronous FIFO control with registered flags and sticky error bits.
module sync_fifo_cell
    import cell_pkg::*;
#(
    parameter int WIDTH = DEF_WIDTH,
    parameter int DEPTH = DEF_DEPTH
) (
    input  logic                   CLK,
    input  logic                   R,
    input  logic                   gnd,
    input  logic                   vdd,
    input  logic                   WEN,
    input  logic [WIDTH-1:0]       D,
    input  logic                   REN,
    output logic [WIDTH-1:0]       Q,
    output logic                   FULL,
    output logic                   EMPTY,
    output logic [clog2(DEPTH):0]  COUNT,
    output logic                   OVF,
    output logic                   UDF
);
    localparam int AW = clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [AW-1:0] r_wr_ptr, r_rd_ptr;
    logic [CW-1:0] r_count;
    logic          r_full, r_empty, r_ovf, r_udf;
    logic          w_rd_acc, w_wr_acc, w_unused;
    logic [CW-1:0] w_count_nxt;

    assign w_unused    = gnd ^ vdd;
    assign w_rd_acc    = REN & ~r_empty;
    assign w_wr_acc    = WEN & (~r_full | w_rd_acc);
    assign w_count_nxt = (w_wr_acc & ~w_rd_acc) ? r_count + 1'b1 :
                         (w_rd_acc & ~w_wr_acc) ? r_count - 1'b1 : r_count;

    always_ff @(posedge CLK) begin
        if (R) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_empty  <= 1'b1;
            r_full   <= 1'b0;
            r_ovf    <= 1'b0;
            r_udf    <= 1'b0;
        end else begin
            if (w_wr_acc) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_rd_acc) r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= w_count_nxt;
            r_empty <= (w_count_nxt == '0);
            r_full  <= (w_count_nxt == CW'(DEPTH));
            if (WEN & ~w_wr_acc) r_ovf <= 1'b1;
            if (REN & r_empty) r_udf <= 1'b1;
        end
    end

    fifo_mem #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) u_mem (
        .i_clk   (CLK),
        .i_rst   (R),
        .i_we    (w_wr_acc & ~R),
        .i_waddr (r_wr_ptr),
        .i_wdata (D),
        .i_re    (w_rd_acc & ~R),
        .i_raddr (r_rd_ptr),
        .o_rdata (Q)
    );

    assign COUNT = r_count;
    assign FULL  = r_full;
    assign EMPTY = r_empty;
    assign OVF   = r_ovf;
    assign UDF   = r_udf;
endmodule

// File: tb/tb_sync_fifo_cell.sv
// tb_sync_fifo_cell: directed + random stimulus against a queue model, scoreboard-checked.
module tb_sync_fifo_cell;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [7:0] q;
        logic [2:0] cnt;
        logic       full, empty, ovf, udf, rd;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst, wen, ren;
    logic [7:0] d;
    logic [7:0] q;
    logic       full, empty, ovf, udf;
    logic [2:0] count;

    int checks = 0;
    int errors = 0;

    logic [7:0] mq[$];
    logic [7:0] exp_q[$];
    rec_t       recs[$];
    logic [7:0] m_q = 8'h00;
    logic       m_ovf = 1'b0, m_udf = 1'b0;

    always #5 clk = ~clk;

    sync_fifo_cell #(.WIDTH(8), .DEPTH(DEPTH)) dut (
        .CLK(clk), .R(rst), .gnd(1'b0), .vdd(1'b1),
        .WEN(wen), .D(d), .REN(ren), .Q(q),
        .FULL(full), .EMPTY(empty), .COUNT(count), .OVF(ovf), .UDF(udf)
    );

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h want %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One cycle: drive inputs, advance the model, and queue what the DUT must show after the edge.
    task automatic drive(input logic r, input logic w, input logic rn, input logic [7:0] dv);
        logic rd_ok, wr_ok;
        rec_t e;
        @(negedge clk);
        rst = r; wen = w; ren = rn; d = dv;
        rd_ok = 1'b0;
        if (r) begin
            mq.delete();
            m_q = 8'h00; m_ovf = 1'b0; m_udf = 1'b0;
        end else begin
            rd_ok = rn && mq.size() > 0;
            wr_ok = w && (mq.size() < DEPTH || rd_ok);
            if (rn && mq.size() == 0) m_udf = 1'b1;
            if (w && !wr_ok) m_ovf = 1'b1;
            if (rd_ok) begin
                m_q = mq.pop_front();
                exp_q.push_back(m_q);
            end
            if (wr_ok) mq.push_back(dv);
        end
        e.q = m_q; e.cnt = 3'(mq.size());
        e.full = mq.size() == DEPTH; e.empty = mq.size() == 0;
        e.ovf = m_ovf; e.udf = m_udf; e.rd = rd_ok;
        recs.push_back(e);
    endtask

    always @(posedge clk) begin
        rec_t e;
        #1;
        if (recs.size() > 0) begin
            e = recs.pop_front();
            chk("count", 32'(count), 32'(e.cnt));
            chk("full",  32'(full),  32'(e.full));
            chk("empty", 32'(empty), 32'(e.empty));
            chk("ovf",   32'(ovf),   32'(e.ovf));
            chk("udf",   32'(udf),   32'(e.udf));
            chk("q_hold", 32'(q),    32'(e.q));
            if (e.rd) begin
                if (exp_q.size() == 0) chk("scoreboard_underrun", 32'd1, 32'd0);
                else chk("q_data", 32'(q), 32'(exp_q.pop_front()));
            end
        end
    end

    initial begin
        rst = 1'b1; wen = 1'b0; ren = 1'b0; d = 8'h00;
        drive(1, 0, 0, 0);
        drive(1, 0, 0, 0);
        foreach (exp_q[i]) exp_q.delete();
        for (int i = 1; i <= 4; i++) drive(0, 1, 0, 8'(i * 8'h11));
        for (int i = 0; i < 4; i++) drive(0, 0, 1, 0);
        for (int i = 1; i <= 4; i++) drive(0, 1, 0, 8'(i * 8'h11));
        drive(0, 1, 0, 8'h55);
        for (int i = 0; i < 4; i++) drive(0, 0, 1, 0);
        drive(1, 0, 0, 0);
        drive(0, 1, 1, 8'hA5);
        drive(0, 0, 1, 0);
        for (int i = 1; i <= 4; i++) drive(0, 1, 0, 8'(8'hC0 + i));
        for (int i = 0; i < 6; i++) drive(0, 1, 1, 8'h66);
        for (int i = 0; i < 5; i++) drive(0, 0, 1, 0);
        drive(1, 0, 0, 0);
        for (int i = 0; i < 3; i++) drive(0, 1, 0, 8'(8'h70 + i));
        drive(1, 1, 0, 8'h99);
        drive(0, 1, 0, 8'h12);
        drive(0, 0, 1, 0);
        for (int i = 0; i < 10000; i++)
            drive($urandom_range(0, 499) == 0, $urandom_range(0, 99) < 55,
                  $urandom_range(0, 99) < 50, 8'($urandom));
        drive(0, 0, 0, 0);
        repeat (3) @(negedge clk);
        chk("scoreboard_drained", 32'(recs.size() + exp_q.size()), 32'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
